// File: rtl/fp32_pkg.sv
// Shared FP32 format constants and field layout for the FP_modules datapath.
package fp32_pkg;
  localparam logic [7:0] FP32_BIAS   = 8'd127;
  localparam int         FP32_EXP_W  = 8;
  localparam int         FP32_MANT_W = 23;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;
endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter with an all-zero flag.
module lzc32 (
  input  logic [31:0] i_val,
  output logic [4:0]  o_cnt,
  output logic        o_zero
);
  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    o_cnt = 5'd0;
    for (int i = 0; i < 32; i++)
      if (i_val[i]) o_cnt = 5'(31 - i);
  end

  assign o_zero = ~|i_val;
endmodule

// File: rtl/signed_int_to_float_unit.sv
// int32 -> FP32 converter, round-to-nearest-even, one output register stage.
module signed_int_to_float_unit
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  input  logic [31:0] signed_int_val,
  output logic        out_vld,
  output logic [31:0] FP_val
);
  logic        w_neg;
  logic [31:0] w_mag;
  logic [31:0] w_norm;
  logic [4:0]  w_lzc;
  logic        w_zero;
  logic [22:0] w_mant_raw;
  logic        w_guard;
  logic        w_sticky;
  logic        w_rnd;
  logic [23:0] w_mant_sum;
  logic [7:0]  w_exp;
  fp32_t       w_res;
  fp32_t       r_fp;
  logic        r_vld;

  // 32'h80000000 negates to itself, which is exactly 2^31 as unsigned.
  assign w_neg = signed_int_val[31];
  assign w_mag = w_neg ? (~signed_int_val + 32'd1) : signed_int_val;

  lzc32 u_lzc (
    .i_val  (w_mag),
    .o_cnt  (w_lzc),
    .o_zero (w_zero)
  );

  // Leading one lands at bit 31; for p<=23 guard/sticky are naturally zero.
  assign w_norm     = w_mag << w_lzc;
  assign w_mant_raw = w_norm[30:8];
  assign w_guard    = w_norm[7];
  assign w_sticky   = |w_norm[6:0];
  assign w_rnd      = w_guard & (w_sticky | w_mant_raw[0]);
  assign w_mant_sum = {1'b0, w_mant_raw} + {23'd0, w_rnd};

  // A mantissa carry-out leaves sum[22:0] all zero and bumps the exponent.
  assign w_exp = FP32_BIAS + {3'd0, 5'd31 - w_lzc} + {7'd0, w_mant_sum[23]};

  always_comb begin
    w_res = '0;
    if (!w_zero) begin
      w_res.sign = w_neg;
      w_res.exp  = w_exp;
      w_res.mant = w_mant_sum[22:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_fp  <= '0;
    end else begin
      r_vld <= in_vld;
      if (in_vld) r_fp <= w_res;
    end
  end

  assign out_vld = r_vld;
  assign FP_val  = r_fp;
endmodule

// File: tb/tb_signed_int_to_float_unit.sv
// Directed + random bench for signed_int_to_float_unit against an arithmetic RNE model.
module tb_signed_int_to_float_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld;
  logic [31:0] din;
  logic        out_vld;
  logic [31:0] FP_val;

  int n_vec  = 0;
  int n_miss = 0;

  logic        m_vld;
  logic [31:0] m_fp;

  signed_int_to_float_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_vld         (in_vld),
    .signed_int_val (din),
    .out_vld        (out_vld),
    .FP_val         (FP_val)
  );

  always #5 clk = ~clk;

  // Reference: integer magnitude, exponent by powers of two, RNE by quotient/remainder.
  function automatic logic [31:0] model(input logic [31:0] x);
    longint m, q, r, half, mant;
    int     e, sh;
    logic [7:0] ef;
    if (x == 32'd0) return 32'h0;
    m = x[31] ? (64'h1_0000_0000 - longint'(x)) : longint'(x);
    e = 0;
    while ((64'd1 << (e + 1)) <= m) e++;
    if (e <= 23) begin
      mant = (m << (23 - e)) - (64'd1 << 23);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (r > half || (r == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e = e + 1;
      end
      mant = q - (64'd1 << 23);
    end
    ef = 8'(127 + e);
    return {x[31], ef, mant[22:0]};
  endfunction

  // Register-level expectation: 1-cycle latency, hold when idle, async clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      m_fp  <= 32'h0;
    end else begin
      m_vld <= in_vld;
      if (in_vld) m_fp <= model(din);
    end
  end

  always @(negedge clk) begin
    n_vec++;
    if (out_vld !== m_vld || FP_val !== m_fp) begin
      n_miss++;
      $display("FAIL cycle_check t=%0t: got vld=%b fp=%h, want vld=%b fp=%h",
               $time, out_vld, FP_val, m_vld, m_fp);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [31:0] x, input logic v);
    din    = x;
    in_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string name, input logic [31:0] x, input logic [31:0] want);
    check({name, "_model"}, model(x), want);
    drive(x, 1'b1);
    check({name, "_vld"}, {31'd0, out_vld}, 32'd1);
    check(name, FP_val, want);
  endtask

  initial begin
    rst_n  = 1'b0;
    in_vld = 1'b0;
    din    = 32'h0;
    #1;
    check("reset_fp", FP_val, 32'h0);
    check("reset_vld", {31'd0, out_vld}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    vec("zero",       32'h00000000, 32'h00000000);
    vec("one",        32'h00000001, 32'h3F800000);
    vec("minus_one",  32'hFFFFFFFF, 32'hBF800000);
    vec("two_p24",    32'd16777216, 32'h4B800000);
    vec("max_pos",    32'h7FFFFFFF, 32'h4F000000);
    vec("min_neg",    32'h80000000, 32'hCF000000);
    vec("tie_even",   32'd16777217, 32'h4B800000);
    vec("tie_up",     32'd16777219, 32'h4B800002);
    vec("neg_tie_up", 32'hFEFFFFFD, 32'hCB800002);
    vec("seven",      32'd7,        32'h40E00000);

    // Idle cycle: value held, valid dropped.
    drive(32'd123, 1'b0);
    check("hold_vld", {31'd0, out_vld}, 32'd0);
    check("hold_fp", FP_val, 32'h40E00000);

    // Reset asserted while a valid input is waiting: result must be dropped.
    vec("pre_rst", 32'd5, 32'h40A00000);
    din    = 32'd9;
    in_vld = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_fp", FP_val, 32'h0);
    check("midrst_vld", {31'd0, out_vld}, 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    in_vld = 1'b0;
    check("post_rst_vld", {31'd0, out_vld}, 32'd0);
    vec("post_rst", 32'd3, 32'h40400000);

    for (int i = 0; i < 1000; i++) drive($urandom, 1'b1);
    for (int i = 0; i < 100; i++) drive($urandom, 1'($urandom_range(0, 1)));
    drive(32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/signed_int_to_float_unit.md
Name: signed_int_to_float_unit

Overview:
- Converts a 32-bit two's-complement signed integer to an IEEE-754 single-precision (FP32) value.
- Lives in the FP_modules datapath, feeding FP arithmetic in the handwriting-recognition accelerator.
- Conversion logic is combinational, followed by one output register stage.
- Rounding is round-to-nearest-even, bit-exact with a SystemVerilog int->shortreal conversion.

Parameters:
- None. Formats are fixed: 32-bit int in, FP32 out.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_vld  input  1  signed_int_val is valid this cycle
- signed_int_val  input  32  signed two's-complement integer
- out_vld  output  1  FP_val holds a new result
- FP_val  output  32  FP32 result {sign[31], exp[30:23], mant[22:0]}

Behaviour:
- Reset:
  - while rst_n=0 (asynchronous): FP_val=32'h00000000 and out_vld=0.
  - Release takes effect at the next clk edge.
- Latency and handshake:
  - Fixed 1-cycle latency, full throughput, no stall or backpressure.
  - At each posedge: out_vld <= in_vld; FP_val <= convert(signed_int_val) when in_vld=1.
  - FP_val holds its previous value when in_vld=0.
- convert(x), zero: x==0 -> 32'h00000000 (positive zero only).
- convert(x), sign and magnitude:
  - sign = x[31].
  - mag = 32-bit unsigned |x|; x=32'h80000000 gives mag=2^31, with no overflow.
- convert(x), normalisation:
  - p = index of the leading one in mag (0..31), via a leading-zero count.
  - exponent = 127 + p; range 127..158.
- convert(x), mantissa when p<=23: mant = (mag << (23-p))[22:0]. Exact, no rounding.
- convert(x), mantissa when p>23:
  - sh = p-23. mant_raw = (mag >> sh)[22:0].
  - guard = mag[sh-1]; sticky = OR of mag[sh-2:0].
  - Round up iff guard && (sticky || mant_raw[0]).
  - If rounding carries out of bit 22: mant = 0, exponent += 1.
- Range: max exponent after rounding is 158 (2^31). Never produces Inf, NaN or denormals.
- Truncation of inexact cases is not permitted. Output must equal RNE exactly.
- Simultaneous events: an asynchronous reset mid-stream drops the in-flight result; out_vld=0 afterwards.

Decomposition:
- Shared package fp32_pkg holds:
  - FP32_BIAS = 8'd127, FP32_EXP_W = 8, FP32_MANT_W = 23.
  - typedef fp32_t as a packed struct {sign, exp, mant}.
- One natural sub-module: lzc32. It is a combinational 32-bit leading-zero counter returning a 5-bit count plus an all-zero flag.
- The top holds abs, shift, round and the output register.

Test Plan:
- Reset and zero: assert rst_n=0 -> FP_val=0, out_vld=0. Release, drive 0 with in_vld=1 -> next cycle FP_val=32'h00000000, out_vld=1.
- Small values: 1 -> 32'h3F800000; -1 -> 32'hBF800000; 16777216 -> 32'h4B800000 (exact).
- Extremes:
  - 32'h7FFFFFFF -> 32'h4F000000 (rounds up, exponent carry).
  - 32'h80000000 -> 32'hCF000000.
- Rounding ties:
  - 16777217 -> 32'h4B800000 (tie, stays even).
  - 16777219 -> 32'h4B800002 (tie, rounds to even).
  - -16777219 -> 32'hCB800002.
- Random: 1000 back-to-back $random inputs, in_vld=1 every cycle. Each output, one cycle later, equals $shortrealtobits($itor(x)) bit-exactly.
- Hold and mid-stream reset:
  - in_vld=0 -> FP_val unchanged, out_vld=0.
  - Pulse rst_n low between two valid inputs -> outputs clear immediately; the next valid input converts correctly.
